// File: rtl/mdc_pkg.sv
// Shared definitions for the mdc requester and anything that talks to the
// mdc core: FSM state encoding, default widths and the response record.
package mdc_pkg;

  // Default operand/result width of the mdc core.
  localparam int MDC_WIDTH = 8;

  // Default width of the cycle counter and the completed-response counter.
  localparam int MDC_CNT_W = 16;

  // Requester FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_START   = 3'd2,
    ST_BUSY    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

  // One response as seen on the response port (default widths).
  typedef struct packed {
    logic [MDC_WIDTH-1:0] dt;
    logic                 err;
    logic [MDC_CNT_W-1:0] cycles;
  } rsp_t;

endpackage

// File: rtl/mdc_req_timer.sv
// Saturating up-counter with synchronous clear and count enable.
// Clear loads 1 so the count reads "cycles elapsed including this one";
// o_tc is high once the count has reached the terminal value TC.
module mdc_req_timer
  import mdc_pkg::*;
#(
  parameter int W  = MDC_CNT_W,
  parameter int TC = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  localparam logic [W-1:0] C_ONE = W'(1);
  localparam logic [W-1:0] C_TC  = W'(TC);

  logic [W-1:0] r_cnt;

  // Count up while enabled, stick at all-ones instead of wrapping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= C_ONE;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + C_ONE;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt >= C_TC);

endmodule

// File: rtl/mdc_requester.sv
// Initiator for the mdc (GCD) core. Takes operand pairs over a request
// port, starts the core with a one-cycle enable, follows its busy flag and
// returns the result with a cycle count and an error flag over a response
// port. Zero operands are answered directly without touching the core.
//
// Handshakes (both ports): a transfer happens on a rising clock edge where
// valid and ready are both high. A source keeps valid and its payload
// stable until that edge; ready may change freely. Here req_ready_o is high
// only while idle, and rsp_valid_o with its payload is held until
// rsp_ready_i is seen.
module mdc_requester
  import mdc_pkg::*;
#(
  parameter int WIDTH      = MDC_WIDTH,
  parameter int START_WAIT = 4,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = MDC_CNT_W
) (
  input  logic             clk,
  input  logic             rst_i,
  // request port
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] req_x_i,
  input  logic [WIDTH-1:0] req_y_i,
  // response port
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_dt_o,
  output logic             rsp_err_o,
  output logic [CNT_W-1:0] rsp_cycles_o,
  // mdc core interface
  output logic             mdc_enb_o,
  output logic [WIDTH-1:0] mdc_dtx_o,
  output logic [WIDTH-1:0] mdc_dty_o,
  input  logic             mdc_busy_i,
  input  logic [WIDTH-1:0] mdc_dt_i,
  // statistics
  output logic [CNT_W-1:0] done_cnt_o
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic             r_req_ready;
  logic             r_enb;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_dt;
  logic             r_rsp_err;
  logic [CNT_W-1:0] r_rsp_cycles;
  logic [CNT_W-1:0] r_done_cnt;

  logic             w_accept;
  logic             w_x_zero;
  logic             w_y_zero;
  logic             w_cyc_clr;
  logic             w_cyc_en;
  logic [CNT_W-1:0] w_cyc_cnt;
  logic             w_cyc_tc;
  logic             w_sw_clr;
  logic             w_sw_en;
  logic [CNT_W-1:0] w_sw_cnt_unused;  // only the terminal compare matters here
  logic             w_sw_tc;

  assign w_accept = (r_state == ST_IDLE) && req_valid_i && r_req_ready;
  assign w_x_zero = (req_x_i == '0);
  assign w_y_zero = (req_y_i == '0);

  // Transaction cycle counter: starts at 1 on accept, runs while the core
  // path is in flight, and its terminal count is the busy timeout.
  assign w_cyc_clr = w_accept;
  assign w_cyc_en  = (r_state == ST_ISSUE) || (r_state == ST_START) ||
                     (r_state == ST_BUSY)  || (r_state == ST_CAPTURE);

  mdc_req_timer #(
    .W  (CNT_W),
    .TC (TIMEOUT)
  ) u_cyc_timer (
    .i_clk (clk),
    .i_rst (rst_i),
    .i_clr (w_cyc_clr),
    .i_en  (w_cyc_en),
    .o_cnt (w_cyc_cnt),
    .o_tc  (w_cyc_tc)
  );

  // Start-wait counter: armed during the enable pulse, counts START cycles.
  assign w_sw_clr = (r_state == ST_ISSUE);
  assign w_sw_en  = (r_state == ST_START);

  mdc_req_timer #(
    .W  (CNT_W),
    .TC (START_WAIT)
  ) u_start_timer (
    .i_clk (clk),
    .i_rst (rst_i),
    .i_clr (w_sw_clr),
    .i_en  (w_sw_en),
    .o_cnt (w_sw_cnt_unused),
    .o_tc  (w_sw_tc)
  );

  // Request/response sequencing with all outputs registered.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b1;
      r_enb        <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_dt     <= '0;
      r_rsp_err    <= 1'b0;
      r_rsp_cycles <= '0;
      r_done_cnt   <= '0;
    end else begin
      r_enb <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_x         <= req_x_i;
            r_y         <= req_y_i;
            if (w_x_zero || w_y_zero) begin
              // gcd(0,v)=v: with one operand zero the OR is the other one.
              r_rsp_dt     <= req_x_i | req_y_i;
              r_rsp_err    <= w_x_zero && w_y_zero;
              r_rsp_cycles <= C_CNT_ONE;
              r_rsp_valid  <= 1'b1;
              r_state      <= ST_RESP;
            end else begin
              r_enb   <= 1'b1;
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_state <= ST_START;
        end
        ST_START: begin
          if (mdc_busy_i) begin
            r_state <= ST_BUSY;
          end else if (w_sw_tc) begin
            // Core never raised busy: it finished within the start window.
            r_state <= ST_CAPTURE;
          end
        end
        ST_BUSY: begin
          if (!mdc_busy_i) begin
            r_state <= ST_CAPTURE;
          end else if (w_cyc_tc) begin
            r_rsp_dt     <= '0;
            r_rsp_err    <= 1'b1;
            r_rsp_cycles <= w_cyc_cnt;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_RESP;
          end
        end
        ST_CAPTURE: begin
          r_rsp_dt     <= mdc_dt_i;
          r_rsp_err    <= 1'b0;
          r_rsp_cycles <= w_cyc_cnt;
          r_rsp_valid  <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            // New requests open only in the cycle after this handshake.
            r_rsp_valid <= 1'b0;
            r_done_cnt  <= r_done_cnt + C_CNT_ONE;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = r_req_ready;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_dt_o     = r_rsp_dt;
  assign rsp_err_o    = r_rsp_err;
  assign rsp_cycles_o = r_rsp_cycles;
  assign mdc_enb_o    = r_enb;
  assign mdc_dtx_o    = r_x;
  assign mdc_dty_o    = r_y;
  assign done_cnt_o   = r_done_cnt;

endmodule

// File: tb/tb_mdc_requester.sv
// Bench for mdc_requester: a behavioural mdc core with programmable busy
// timing, a GCD reference model and a scoreboard of expected responses.
module tb_mdc_requester;
  import mdc_pkg::*;

  localparam int W  = MDC_WIDTH;
  localparam int CW = MDC_CNT_W;
  localparam int SW = 4;
  localparam int TO = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [W-1:0]  req_x_i = '0;
  logic [W-1:0]  req_y_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [W-1:0]  rsp_dt_o;
  logic          rsp_err_o;
  logic [CW-1:0] rsp_cycles_o;
  logic          mdc_enb_o;
  logic [W-1:0]  mdc_dtx_o;
  logic [W-1:0]  mdc_dty_o;
  logic          mdc_busy_i = 1'b0;
  logic [W-1:0]  mdc_dt_i = '0;
  logic [CW-1:0] done_cnt_o;

  mdc_requester #(
    .WIDTH      (W),
    .START_WAIT (SW),
    .TIMEOUT    (TO),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_x_i      (req_x_i),
    .req_y_i      (req_y_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_dt_o     (rsp_dt_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_cycles_o (rsp_cycles_o),
    .mdc_enb_o    (mdc_enb_o),
    .mdc_dtx_o    (mdc_dtx_o),
    .mdc_dty_o    (mdc_dty_o),
    .mdc_busy_i   (mdc_busy_i),
    .mdc_dt_i     (mdc_dt_i),
    .done_cnt_o   (done_cnt_o)
  );

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return W'(a);
  endfunction

  // ---------------- behavioural mdc core ----------------
  // rise: edges after the enable is taken until busy goes high (0 = never,
  // result is ready at once); hold: cycles busy stays high; hang: busy stays
  // high until core_release.
  int core_rise = 1;
  int core_hold = 1;
  bit core_hang = 1'b0;
  bit core_release = 1'b0;
  int enb_cnt = 0;

  initial begin : core_model
    logic [W-1:0] g;
    forever begin
      @(negedge clk);
      if (mdc_enb_o === 1'b1) begin
        g = ref_gcd(int'(mdc_dtx_o), int'(mdc_dty_o));
        @(posedge clk); #1;
        if (core_rise == 0) begin
          mdc_dt_i = g;
        end else begin
          mdc_dt_i = W'($urandom);
          if (core_rise > 1) begin
            repeat (core_rise - 1) @(posedge clk);
            #1;
          end
          mdc_busy_i = 1'b1;
          if (core_hang) begin
            wait (core_release);
          end else begin
            repeat (core_hold) @(posedge clk);
            #1;
          end
          mdc_busy_i = 1'b0;
          mdc_dt_i   = g;
        end
      end
    end
  end

  initial begin : enb_monitor
    forever begin
      @(negedge clk);
      if (mdc_enb_o === 1'b1) enb_cnt++;
    end
  end

  // ---------------- scoreboard ----------------
  rsp_t exp_q[$];
  int   exp_done = 0;

  // ---------------- driver ----------------
  task automatic do_txn(input logic [W-1:0] x, input logic [W-1:0] y,
                        input int rise, input int hold, input bit hang, input int bp);
    rsp_t         e;
    int           e_lat;
    int           lat;
    int           guard;
    int           enb0;
    int           stable_bad;
    logic [W-1:0] dt0;
    bit           shortcut;

    shortcut  = (x == '0) || (y == '0);
    core_rise = rise;
    core_hold = hold;
    core_hang = hang;

    e.dt  = (hang && !shortcut) ? '0 : ref_gcd(int'(x), int'(y));
    e.err = (hang && !shortcut) || ((x == '0) && (y == '0));
    if (shortcut)       e.cycles = CW'(1);
    else if (hang)      e.cycles = CW'(TO);
    else if (rise == 0) e.cycles = CW'(SW + 2);
    else                e.cycles = CW'(rise + hold + 2);
    e_lat = shortcut ? 0 : int'(e.cycles);
    exp_q.push_back(e);

    enb0 = enb_cnt;
    @(posedge clk); #1;
    req_valid_i = 1'b1;
    req_x_i     = x;
    req_y_i     = y;
    guard = 0;
    @(negedge clk);
    while (!req_ready_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_val("req_ready_before_accept", req_ready_o, 1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    req_x_i     = W'($urandom);
    req_y_i     = W'($urandom);

    lat = 0;
    @(negedge clk);
    while (!rsp_valid_o && lat < TO + 100) begin
      @(negedge clk);
      lat++;
    end
    e = exp_q.pop_front();
    check_val("rsp_valid", rsp_valid_o, 1);
    check_val("rsp_dt", rsp_dt_o, e.dt);
    check_val("rsp_err", rsp_err_o, e.err);
    check_val("rsp_cycles", rsp_cycles_o, e.cycles);
    check_val("latency", lat, e_lat);
    check_val("enb_pulses", enb_cnt - enb0, shortcut ? 0 : 1);

    dt0 = rsp_dt_o;
    stable_bad = 0;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (!rsp_valid_o || (rsp_dt_o !== dt0) || req_ready_o) stable_bad++;
    end
    if (bp > 0) check_val("rsp_hold_stable", stable_bad, 0);

    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    exp_done++;
    @(negedge clk);
    check_val("rsp_valid_after_hs", rsp_valid_o, 0);
    check_val("req_ready_after_hs", req_ready_o, 1);
    check_val("done_cnt", done_cnt_o, exp_done);

    if (hang) begin
      core_release = 1'b1;
      @(posedge clk); #1;
      core_release = 1'b0;
      core_hang    = 1'b0;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #3000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    int           mode;

    repeat (3) @(negedge clk);
    check_val("rst_req_ready", req_ready_o, 1);
    check_val("rst_rsp_valid", rsp_valid_o, 0);
    check_val("rst_enb", mdc_enb_o, 0);
    check_val("rst_done_cnt", done_cnt_o, 0);
    check_val("rst_dtx", mdc_dtx_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    check_val("post_rst_req_ready", req_ready_o, 1);

    // directed cases
    do_txn(8'd48, 8'd18, 1, 5, 1'b0, 0);
    do_txn(8'd0, 8'd35, 1, 1, 1'b0, 0);
    do_txn(8'd35, 8'd0, 1, 1, 1'b0, 0);
    do_txn(8'd0, 8'd0, 1, 1, 1'b0, 0);
    do_txn(8'd255, 8'd1, 2, 3, 1'b0, 20);
    do_txn(8'd17, 8'd51, 0, 1, 1'b0, 0);
    do_txn(8'd100, 8'd75, SW, 2, 1'b0, 1);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      mode = $urandom_range(0, 11);
      rx = W'($urandom_range(1, 255));
      ry = W'($urandom_range(1, 255));
      if (mode == 0) rx = '0;
      if (mode == 1) ry = '0;
      if (mode == 2) begin rx = '0; ry = '0; end
      do_txn(rx, ry, $urandom_range(0, SW), $urandom_range(1, 12), 1'b0,
             $urandom_range(0, 3));
    end

    // busy stuck high
    do_txn(8'd90, 8'd60, 1, 1, 1'b1, 2);

    // reset while the core is busy
    core_rise = 1;
    core_hang = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b1;
    req_x_i     = 8'd200;
    req_y_i     = 8'd150;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    repeat (10) @(negedge clk);
    check_val("pre_rst_busy_no_rsp", rsp_valid_o, 0);
    rst_i = 1'b1;
    #1;
    check_val("midrst_req_ready", req_ready_o, 1);
    check_val("midrst_rsp_valid", rsp_valid_o, 0);
    check_val("midrst_enb", mdc_enb_o, 0);
    check_val("midrst_done_cnt", done_cnt_o, 0);
    check_val("midrst_dtx", mdc_dtx_o, 0);
    check_val("midrst_rsp_dt", rsp_dt_o, 0);
    exp_done = 0;
    core_release = 1'b1;
    @(posedge clk); #1;
    core_release = 1'b0;
    core_hang    = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    check_val("post_midrst_no_rsp", rsp_valid_o, 0);
    do_txn(8'd200, 8'd150, 2, 7, 1'b0, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
